regfile_write_arbiter: RTL

//   Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, ...).

---
 rtl/regfile_write_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter sharing the single register-file write port among
//   NUM_REQ writeback sources, plus a one-register-per-cycle bulk clear sweep.
//   Outputs to the array (write strobes, index, data) are registered: a
//   transfer in cycle N appears on rf_* in cycle N+1.
//   Optional feature: define RF_ARB_FWD_EN to add a combinational read
//   forwarding path (rd_addr, rd_data_rf -> rd_data).
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic                             clear_start,
    output logic                             clear_busy,
    output logic                             clear_done,
    output logic [(2**ADDR_WIDTH)-1:0]       rf_write_en,
    output logic [ADDR_WIDTH-1:0]            rf_addr,
    output logic [DATA_WIDTH-1:0]            rf_data
`ifdef RF_ARB_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            rd_data_rf,
    output logic [DATA_WIDTH-1:0]            rd_data
`endif
);

    localparam int NREG  = 2 ** ADDR_WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [NREG-1:0]         r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_arb_en;
    logic                    w_found;
    logic [NUM_REQ-1:0]      w_ready;
    logic [PTR_W-1:0]        w_win;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_drop;

    // A pending clear start pre-empts arbitration in the same cycle.
    assign w_arb_en = (r_state != S_CLEAR) && !clear_start;

    // Round-robin search: first valid requester starting at ptr+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_ready = '0;
        w_win   = r_ptr;
        w_addr  = '0;
        w_data  = '0;
        if (w_arb_en) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && req_valid[i] &&
                        (i == ((32'(r_ptr) + k) % NUM_REQ))) begin
                        w_found    = 1'b1;
                        w_ready[i] = 1'b1;
                        w_win      = PTR_W'(i);
                        w_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        w_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Writes to r0 complete the handshake but never strobe the array.
    assign w_drop = (ZERO_REG != 0) && (w_addr == '0);

    // Control FSM with registered write-port outputs and clear status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= PTR_W'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_we   <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (clear_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        if (w_found) begin
                            r_ptr  <= w_win;
                            r_addr <= w_addr;
                            r_data <= w_data;
                            if (!w_drop) begin
                                r_we[w_addr] <= 1'b1;
                            end
                        end
                        r_state <= (|req_valid) ? S_RUN : S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_we[r_cnt] <= 1'b1;
                    r_addr      <= r_cnt;
                    r_data      <= '0;
                    if (r_cnt == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign clear_busy  = r_busy;
    assign clear_done  = r_done;
    assign rf_write_en = r_we;
    assign rf_addr     = r_addr;
    assign rf_data     = r_data;

`ifdef RF_ARB_FWD_EN
    // Bypass the array when this cycle's write targets the read index.
    assign rd_data = ((ZERO_REG != 0) && (rd_addr == '0)) ? '0 :
                     (r_we[rd_addr] ? r_data : rd_data_rf);
`endif

endmodule
